// File: rtl/dram_link_sequencer_if.sv
// Descriptor, DRAM-model and eyeriss handshake bundle for dram_link_sequencer.
// master: sequencer side; slave: descriptor source, DRAM model and eyeriss side.
interface dram_link_sequencer_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 20,
    parameter int WORDS_WIDTH = 16,
    parameter int TYPE_WIDTH  = 3
);
    // descriptor push
    logic                   desc_valid;
    logic                   desc_ready;
    logic                   desc_dir;
    logic [TYPE_WIDTH-1:0]  desc_type;
    logic [ADDR_WIDTH-1:0]  desc_base;
    logic [WORDS_WIDTH-1:0] desc_words;
    // DRAM model port
    logic                   mem_re;
    logic [ADDR_WIDTH-1:0]  mem_raddr;
    logic [DATA_WIDTH-1:0]  mem_rdata;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_waddr;
    logic [DATA_WIDTH-1:0]  mem_wdata;
    // eyeriss pins
    logic [WORDS_WIDTH-1:0] words_num;
    logic [TYPE_WIDTH-1:0]  transfer_type;
    logic                   start_forward;
    logic                   start_backward;
    logic                   re_from_dram;
    logic [DATA_WIDTH-1:0]  rdata_from_dram;
    logic                   valid_from_dram;
    logic                   we_to_dram;
    logic [DATA_WIDTH-1:0]  wdata_to_dram;
    logic                   transfer_done;

    modport master (
        input  desc_valid, desc_dir, desc_type, desc_base, desc_words,
        input  mem_rdata,
        input  re_from_dram, we_to_dram, wdata_to_dram, transfer_done,
        output desc_ready,
        output mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
        output words_num, transfer_type, start_forward, start_backward,
        output rdata_from_dram, valid_from_dram
    );

    modport slave (
        output desc_valid, desc_dir, desc_type, desc_base, desc_words,
        output mem_rdata,
        output re_from_dram, we_to_dram, wdata_to_dram, transfer_done,
        input  desc_ready,
        input  mem_re, mem_raddr, mem_we, mem_waddr, mem_wdata,
        input  words_num, transfer_type, start_forward, start_backward,
        input  rdata_from_dram, valid_from_dram
    );
endinterface

// File: rtl/dram_link_sequencer.sv
// DRAM-side transfer sequencer: queues descriptors and drives the eyeriss
// forward/backward handshake against a 1-cycle-read DRAM model port.
// Ports: core_clk, reset (sync, active-high), bus (master modport: descriptor
// push, DRAM model port, eyeriss pins), busy, desc_done_cnt, err (sticky).
// Optional: define DRAM_LINK_CHECKSUM_EN to add the 32-bit checksum output.
module dram_link_sequencer #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 20,
    parameter int WORDS_WIDTH = 16,
    parameter int TYPE_WIDTH  = 3,
    parameter int DESC_DEPTH  = 8,
    parameter int TIMEOUT     = 4096
) (
    input  logic                  core_clk,
    input  logic                  reset,
    dram_link_sequencer_if.master bus,
    output logic                  busy,
    output logic [15:0]           desc_done_cnt,
    output logic                  err
`ifdef DRAM_LINK_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam int PTR_W  = $clog2(DESC_DEPTH);
    localparam int DESC_W = 1 + TYPE_WIDTH + ADDR_WIDTH + WORDS_WIDTH;
    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_FWD,
        S_BWD,
        S_WAIT_DONE
    } state_t;

    state_t state;

    logic [DESC_W-1:0]      fifo_mem [DESC_DEPTH];
    logic [PTR_W:0]         wr_ptr;
    logic [PTR_W:0]         rd_ptr;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    logic                   head_dir;
    logic [TYPE_WIDTH-1:0]  head_type;
    logic [ADDR_WIDTH-1:0]  head_base;
    logic [WORDS_WIDTH-1:0] head_words;

    logic                   cur_dir;
    logic [ADDR_WIDTH-1:0]  cur_base;
    logic [WORDS_WIDTH-1:0] cur_words;
    logic [WORDS_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0]  cur_addr;

    logic [WORDS_WIDTH-1:0] words_num_q;
    logic [TYPE_WIDTH-1:0]  type_q;
    logic                   start_fwd_q;
    logic                   start_bwd_q;
    logic                   valid_q;

    logic [WD_W-1:0]        wd_cnt;
    logic                   wd_active;
    logic                   wd_fire;
    logic                   activity;
    logic                   rd_fire;
    logic                   wr_fire;
    logic                   last_word;
    logic                   overrun;
    logic                   retire;

    // ---------------- descriptor FIFO ----------------
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = (state == S_IDLE) && !fifo_empty;
    // a pop in the same cycle frees the slot a full FIFO needs
    assign bus.desc_ready = !fifo_full || pop;
    assign push       = bus.desc_valid && bus.desc_ready;

    assign {head_dir, head_type, head_base, head_words} =
        fifo_mem[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge core_clk) begin
        if (push)
            fifo_mem[wr_ptr[PTR_W-1:0]] <= {bus.desc_dir, bus.desc_type,
                                            bus.desc_base, bus.desc_words};
    end

    always_ff @(posedge core_clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (pop)
                rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // ---------------- transfer datapath ----------------
    assign cur_addr  = cur_base + ADDR_WIDTH'(idx);
    assign last_word = (idx == cur_words - WORDS_WIDTH'(1));
    assign rd_fire   = (state == S_FWD) && bus.re_from_dram &&
                       (idx < cur_words);
    assign wr_fire   = (state == S_BWD) && bus.we_to_dram &&
                       (idx < cur_words);
    // in WAIT_DONE every word has been moved, so any further strobe overruns
    assign overrun   = (state == S_WAIT_DONE) &&
                       (cur_dir ? bus.we_to_dram : bus.re_from_dram);
    assign activity  = bus.re_from_dram || bus.we_to_dram ||
                       bus.transfer_done;
    assign wd_active = (state == S_FWD) || (state == S_BWD) ||
                       (state == S_WAIT_DONE);

    generate
        if (TIMEOUT == 0) begin : g_no_wd
            assign wd_fire = 1'b0;
        end else begin : g_wd
            assign wd_fire = wd_active && !activity &&
                             (wd_cnt == WD_W'(TIMEOUT - 1));
        end
    endgenerate

    // a final backward word and transfer_done may share a cycle
    assign retire = wd_fire ||
                    ((state == S_WAIT_DONE) && bus.transfer_done) ||
                    (wr_fire && last_word && bus.transfer_done);

    assign bus.mem_re          = rd_fire;
    assign bus.mem_raddr       = cur_addr;
    assign bus.mem_we          = wr_fire;
    assign bus.mem_waddr       = cur_addr;
    assign bus.mem_wdata       = wr_fire ? bus.wdata_to_dram : '0;
    assign bus.valid_from_dram = valid_q;
    assign bus.rdata_from_dram = valid_q ? bus.mem_rdata : '0;
    assign bus.words_num       = words_num_q;
    assign bus.transfer_type   = type_q;
    assign bus.start_forward   = start_fwd_q;
    assign bus.start_backward  = start_bwd_q;

    assign busy = (state != S_IDLE) || !fifo_empty;

    // ---------------- sequencer FSM ----------------
    always_ff @(posedge core_clk) begin
        if (reset) begin
            state         <= S_IDLE;
            cur_dir       <= 1'b0;
            cur_base      <= '0;
            cur_words     <= '0;
            idx           <= '0;
            words_num_q   <= '0;
            type_q        <= '0;
            start_fwd_q   <= 1'b0;
            start_bwd_q   <= 1'b0;
            valid_q       <= 1'b0;
            wd_cnt        <= '0;
            desc_done_cnt <= '0;
            err           <= 1'b0;
        end else begin
            start_fwd_q <= 1'b0;
            start_bwd_q <= 1'b0;
            valid_q     <= rd_fire;

            if (wd_active && !activity)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;

            if (overrun || wd_fire)
                err <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (pop) begin
                        if (head_words == '0) begin
                            desc_done_cnt <= desc_done_cnt + 16'd1;
                        end else begin
                            cur_dir     <= head_dir;
                            cur_base    <= head_base;
                            cur_words   <= head_words;
                            idx         <= '0;
                            words_num_q <= head_words;
                            type_q      <= head_type;
                            start_fwd_q <= !head_dir;
                            start_bwd_q <= head_dir;
                            state       <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    state <= cur_dir ? S_BWD : S_FWD;
                end
                S_FWD: begin
                    if (rd_fire) begin
                        idx <= idx + WORDS_WIDTH'(1);
                        if (last_word)
                            state <= S_WAIT_DONE;
                    end
                end
                S_BWD: begin
                    if (wr_fire) begin
                        idx <= idx + WORDS_WIDTH'(1);
                        if (last_word)
                            state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    state <= S_WAIT_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // retire overrides the per-state next state above
            if (retire) begin
                desc_done_cnt <= desc_done_cnt + 16'd1;
                words_num_q   <= '0;
                type_q        <= '0;
                state         <= S_IDLE;
            end
        end
    end

`ifdef DRAM_LINK_CHECKSUM_EN
    logic [31:0] csum_q;

    // cleared on the launch edge, frozen after retire until the next launch
    always_ff @(posedge core_clk) begin
        if (reset)
            csum_q <= '0;
        else if (pop && (head_words != '0))
            csum_q <= '0;
        else if (valid_q)
            csum_q <= csum_q + bus.mem_rdata[31:0];
        else if (wr_fire)
            csum_q <= csum_q + bus.wdata_to_dram[31:0];
    end

    assign checksum = csum_q;
`else
    // no checksum state in this build
`endif

endmodule
